hilo_ctrl: RTL
==============

// Module: hilo_ctrl
// PURPOSE
//  EX-stage multiply/divide controller and HI/LO register file. Decodes MULT/MULTU/DIV/MTHI/MTLO/MFHI/MFLO.
//  Launches the iterative signed divider and consumes its quotient/remainder into LO/HI.
//  Computes products on its own, serves MFHI/MFLO reads, and stalls the pipeline while HI/LO is pending.
// PARAMETERS
//  DW          32   datapath width; HI/LO and operands are DW bits
//  HILO_RST    0    reset value of HI and LO
// PORTS
//  clk           in   1     rising-edge clock
//  reset         in   1     reset, synchronous, active-high
//  ex_valid      in   1     EX-stage instruction valid
//  ex_op         in   3     0 NOP,1 MULT,2 MULTU,3 DIV,4 MTHI,5 MTLO,6 MFHI,7 MFLO
//  ex_flush      in   1     kill EX instruction this cycle (no issue)
//  rs_val        in   DW    operand A / dividend / MTxx data
//  rt_val        in   DW    operand B / divisor
//  pipe_hold     in   1     downstream pipeline frozen; no issue this cycle
//  prog_load     in   1     program-load freeze; passed to divider, FSM holds
//  md_stall      out  1     request pipeline stall (combinational)
//  mf_data       out  DW    HI or LO for MFHI/MFLO (combinational, valid when !md_stall)
//  hi, lo        out  DW    architectural HI/LO registers
//  div_start     out  1     one-cycle pulse launching divider
//  div_dividend  out  DW    registered copy of rs_val at launch
//  div_divisor   out  DW    registered copy of rt_val at launch
//  div_cpu_stall out  1     = prog_load
//  div_busy      in   1     divider iterating
//  div_finish    in   1     one-cycle pulse: div_q/div_r valid
//  div_q, div_r  in   DW    signed quotient / remainder (remainder takes dividend sign)
// BEHAVIOUR
//  Reset: state IDLE; hi=lo=HILO_RST; prod=0; div_start=0; div_dividend=div_divisor=0.
//  issue = ex_valid & !ex_flush & !pipe_hold & !prog_load & ex_op!=0 & !md_stall.
//  md_stall = ex_valid & !ex_flush & ex_op!=0 & state!=IDLE.
//   - Non-HI/LO instructions never stall; a DIV runs under them.
//  States: IDLE, MUL, DIV_WAIT. prog_load=1 freezes every state register.
//  IDLE:
//   - MTHI/MTLO: hi/lo <= rs_val at issue edge; state stays IDLE.
//   - MFHI/MFLO: mf_data = hi/lo same cycle, no stall.
//   - MULT/MULTU: prod <= 2*DW signed/unsigned product of rs_val*rt_val; -> MUL.
//   - DIV, rt_val!=0: latch operands, div_start=1 next cycle only; -> DIV_WAIT.
//   - DIV, rt_val==0: no divider launch; hi<=rs_val, lo<=all-ones; stay IDLE.
//  MUL: {hi,lo} <= prod; -> IDLE. Latency issue->HI/LO visible = 2 cycles.
//  DIV_WAIT: on div_finish: hi<=div_r, lo<=div_q; -> IDLE.
//   - A HI/LO op arriving in the finish cycle still stalls; it issues next cycle with the new values.
//  Overflow: DIV 0x80000000 / -1 takes divider result unmodified (lo=0x80000000, hi=0).
//  div_finish outside DIV_WAIT: ignored. div_start never asserts while div_busy=1.
//  ex_flush with a pending DIV: the launched divide completes and writes HI/LO (already issued).
//  Reset mid-DIV: -> IDLE, HI/LO restored; divider shares reset; late div_finish ignored.
//  mf_data = (ex_op==6) ? hi : lo.
// STRUCTURE
//  Shared package md_pkg: md_op_e enum (3-bit ex_op codes above), hilo_state_e enum, DW default.
//  Sub-module mul_unit: registered DW x DW -> 2*DW multiplier with signed/unsigned select (1-cycle latency).
//  Divider stays external; connected by the div_* ports.
// TESTING
//  MULT rs=-3 (0xFFFFFFFD), rt=7 -> after 2 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU same operands -> hi=0x6, lo=0xFFFFFFEB.
//  DIV rs=-7, rt=2 -> single div_start pulse; on div_finish lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   - Following MFLO stalls until the cycle after finish, then reads 0xFFFFFFFD.
//  DIV rt=0, rs=0x1234 -> no div_start; next cycle hi=0x1234, lo=0xFFFFFFFF; no stall.
//  MTHI 0xA5A5A5A5 then MFHI back-to-back -> mf_data=0xA5A5A5A5, md_stall=0 throughout.
//  DIV launched, then reset asserted before div_finish -> hi=lo=0, state IDLE; stale div_finish pulse leaves hi/lo=0.
//  prog_load=1 for 5 cycles mid-DIV -> div_cpu_stall=1, FSM frozen; result written correctly after release.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the EX-stage multiply/divide block: instruction codes,
// HI/LO controller states and the default datapath width.
package md_pkg;

    localparam int MD_DW = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_WAIT = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/mul_unit.sv
// Registered DW x DW -> 2*DW multiplier; sgn selects signed or unsigned
// operands. The product appears one cycle after en.
module mul_unit
    import md_pkg::*;
#(
    parameter int DW = MD_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sgn,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic [2*DW-1:0]   prod_p1
);

    logic signed [2*DW-1:0] a_ext;
    logic signed [2*DW-1:0] b_ext;

    // Extending both operands to 2*DW makes one modular multiply serve both modes.
    assign a_ext = {{DW{sgn & a[DW-1]}}, a};
    assign b_ext = {{DW{sgn & b[DW-1]}}, b};

    // Stage p0 -> p1: product register
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_p1 <= '0;
        end else if (en) begin
            prod_p1 <= $unsigned(a_ext * b_ext);
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage multiply/divide controller and HI/LO register file. Products are
// computed locally; divides are handed to an external iterative divider.
module hilo_ctrl
    import md_pkg::*;
#(
    parameter int            DW       = MD_DW,
    parameter logic [DW-1:0] HILO_RST = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    input  logic [2:0]    ex_op,
    input  logic          ex_flush,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    input  logic          pipe_hold,
    input  logic          prog_load,
    output logic          md_stall,
    output logic [DW-1:0] mf_data,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          div_start,
    output logic [DW-1:0] div_dividend,
    output logic [DW-1:0] div_divisor,
    output logic          div_cpu_stall,
    input  logic          div_busy,
    input  logic          div_finish,
    input  logic [DW-1:0] div_q,
    input  logic [DW-1:0] div_r
);

    md_op_e          op;
    hilo_state_e     state;
    hilo_state_e     state_nxt;
    logic            issue;
    logic            is_mul;
    logic            div_zero;
    logic            launch_div;
    logic [2*DW-1:0] prod_p1;

    assign op            = md_op_e'(ex_op);
    assign div_cpu_stall = prog_load;

    // md_stall only fires outside IDLE, so issue also implies state == IDLE.
    assign issue      = ex_valid & ~ex_flush & ~pipe_hold & ~prog_load
                      & (op != OP_NOP) & ~md_stall;
    assign is_mul     = (op == OP_MULT) | (op == OP_MULTU);
    assign div_zero   = (rt_val == '0);
    assign launch_div = issue & (op == OP_DIV) & ~div_zero & ~div_busy;

    mul_unit #(.DW(DW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .en      (issue & is_mul),
        .sgn     (op == OP_MULT),
        .a       (rs_val),
        .b       (rt_val),
        .prod_p1 (prod_p1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (!prog_load) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (issue && is_mul) begin
                    state_nxt = ST_MUL;
                end else if (launch_div) begin
                    state_nxt = ST_DIV_WAIT;
                end
            end
            ST_MUL:      state_nxt = ST_IDLE;
            ST_DIV_WAIT: if (div_finish) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        md_stall = ex_valid & ~ex_flush & (op != OP_NOP) & (state != ST_IDLE);
        mf_data  = (op == OP_MFHI) ? hi : lo;
    end

    // HI/LO writeback and divider launch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi           <= HILO_RST;
            lo           <= HILO_RST;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (!prog_load) begin
            div_start <= launch_div;
            if (launch_div) begin
                div_dividend <= rs_val;
                div_divisor  <= rt_val;
            end
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        case (op)
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            OP_DIV: begin
                                // Divide by zero never reaches the divider.
                                if (div_zero) begin
                                    hi <= rs_val;
                                    lo <= '1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: {hi, lo} <= prod_p1;
                ST_DIV_WAIT: begin
                    if (div_finish) begin
                        hi <= div_r;
                        lo <= div_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
